// File: rtl/tpi_hs_source.sv
// Port-A strobe handshake source for the 6525 TPI: FIFO-buffered bytes are driven
// on PA, strobed into PC3, and retired on the CA falling edge. Option: TPI_HS_TIMEOUT_EN.
module tpi_hs_source #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SETUP_LEN   = 2,
  parameter int unsigned STB_LEN     = 4,
  parameter int unsigned STB_POL     = 0,
  parameter int unsigned TIMEOUT_LEN = 65535
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [7:0]                 pa_data,
  output logic                       pa_oe,
  output logic                       strobe,
  input  logic                       ca,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       timeout,
  input  logic                       timeout_clr
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned LW     = $clog2(DEPTH + 1);
  localparam int unsigned PH_MAX = (SETUP_LEN > STB_LEN) ? SETUP_LEN : STB_LEN;
  localparam int unsigned PW     = $clog2(PH_MAX + 1);
  localparam logic [PW-1:0] SETUP_LAST = PW'(SETUP_LEN - 1);
  localparam logic [PW-1:0] STB_LAST   = PW'(STB_LEN - 1);
  localparam logic          STB_ACT    = 1'(STB_POL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_WAIT_ACK,
    S_HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] ph_cnt_q, ph_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic          ca_s1_q, ca_s1_d;
  logic          ca_s_q, ca_s_d;
  logic          ca_prev_q, ca_prev_d;
  logic [7:0]    mem_q [DEPTH];

  logic push_fire;
  logic pop;
  logic ack;

  assign in_ready  = (count_q != LW'(DEPTH));
  assign push_fire = in_valid & in_ready;
  assign ack       = ca_prev_q & ~ca_s_q;

  assign pa_oe   = (state_q != S_IDLE);
  assign busy    = (state_q != S_IDLE);
  assign pa_data = pa_oe ? mem_q[rd_ptr_q] : '0;
  assign strobe  = (state_q == S_STROBE) ? STB_ACT : ~STB_ACT;
  assign level   = count_q;

`ifdef TPI_HS_TIMEOUT_EN
  localparam logic [16:0] TO_LAST = 17'(TIMEOUT_LEN - 1);

  logic [16:0] to_cnt_q, to_cnt_d;
  logic        timeout_q, timeout_d;
  logic        to_set;

  assign timeout = timeout_q;
`else
  logic unused_ok;

  assign timeout   = 1'b0;
  assign unused_ok = timeout_clr ^ (TIMEOUT_LEN == 0);
`endif

  always_comb begin
    state_d   = state_q;
    ph_cnt_d  = ph_cnt_q;
    pop       = 1'b0;
    ca_s1_d   = ca;
    ca_s_d    = ca_s1_q;
    ca_prev_d = ca_s_q;
`ifdef TPI_HS_TIMEOUT_EN
    to_set    = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        ph_cnt_d = '0;
        if ((count_q != '0) && !ca_s_q) state_d = S_SETUP;
      end
      S_SETUP: begin
        if (ph_cnt_q == SETUP_LAST) begin
          ph_cnt_d = '0;
          state_d  = S_STROBE;
        end else begin
          ph_cnt_d = ph_cnt_q + PW'(1);
        end
      end
      S_STROBE: begin
        if (ph_cnt_q == STB_LAST) begin
          ph_cnt_d = '0;
          state_d  = S_WAIT_ACK;
        end else begin
          ph_cnt_d = ph_cnt_q + PW'(1);
        end
      end
      S_WAIT_ACK: begin
        ph_cnt_d = '0;
        // Ack is tested first so it beats a simultaneous expiry.
        if (ack) begin
          state_d = S_HOLD;
        end
`ifdef TPI_HS_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          to_set  = 1'b1;
          pop     = 1'b1;
          state_d = S_IDLE;
        end
`endif
      end
      S_HOLD: begin
        ph_cnt_d = '0;
        pop      = 1'b1;
        if (((count_q > LW'(1)) || push_fire) && !ca_s_q) state_d = S_SETUP;
        else                                              state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + AW'(push_fire);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + LW'(push_fire) - LW'(pop);
  end

`ifdef TPI_HS_TIMEOUT_EN
  always_comb begin
    to_cnt_d  = (state_q == S_WAIT_ACK) ? (to_cnt_q + 17'd1) : '0;
    timeout_d = timeout_q;
    if (timeout_clr) timeout_d = 1'b0;
    if (to_set)      timeout_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ph_cnt_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ca_s1_q   <= 1'b0;
      ca_s_q    <= 1'b0;
      ca_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_cnt_q  <= ph_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ca_s1_q   <= ca_s1_d;
      ca_s_q    <= ca_s_d;
      ca_prev_q <= ca_prev_d;
    end
  end

  // Storage needs no reset: pa_data is gated by pa_oe and pointers are reset.
  always_ff @(posedge clk) begin
    if (push_fire) mem_q[wr_ptr_q] <= in_data;
  end

endmodule
